// File: rtl/ofm_pkg.sv
// ofm_pkg -- shared constants and types for the OFM collector.
//   NUM_PE          : number of PEs feeding bytes (one slot each)
//   BYTES_PER_WORD  : bytes packed into one OFM buffer write
//   WORDS_PER_PIXEL : writes needed to drain one 16-byte group
//   state_e         : collector FSM state encoding
package ofm_pkg;

   localparam int NUM_PE          = 16;
   localparam int BYTES_PER_WORD  = 4;
   localparam int WORDS_PER_PIXEL = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

   // Slot mask covered by drain word k.
   function automatic logic [NUM_PE-1:0] word_mask(input logic [1:0] k);
      logic [NUM_PE-1:0] base;
      base = {{(NUM_PE-BYTES_PER_WORD){1'b0}}, {BYTES_PER_WORD{1'b1}}};
      return base << {k, 2'b00};
   endfunction

endpackage

// File: rtl/ofm_slot_bank.sv
// ofm_slot_bank -- 16 byte slots with pending flags.
//   clk, reset_n  : clock, async active-low reset
//   active_i      : captures allowed (collector not idle)
//   clear_i       : drop all pending flags (layer start / layer end)
//   valid_i       : per-PE capture strobes
//   free_i        : slots released by an accepted write this cycle
//   data_i        : per-PE bytes
//   slot_o        : slot contents
//   pending_o     : current pending flags
//   pending_nxt_o : pending flags after this clock edge
//   overflow_o    : a strobe hit a slot that is still occupied
module ofm_slot_bank
   import ofm_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   active_i,
   input  logic                   clear_i,
   input  logic [NUM_PE-1:0]      valid_i,
   input  logic [NUM_PE-1:0]      free_i,
   input  logic [NUM_PE-1:0][7:0] data_i,
   output logic [NUM_PE-1:0][7:0] slot_o,
   output logic [NUM_PE-1:0]      pending_o,
   output logic [NUM_PE-1:0]      pending_nxt_o,
   output logic                   overflow_o
);

   logic [NUM_PE-1:0][7:0] slot_q, slot_d;
   logic [NUM_PE-1:0]      pending_q, pending_d;
   logic [NUM_PE-1:0]      cap;

   // A slot being freed this cycle may be refilled in the same cycle.
   assign cap        = active_i ? (valid_i & (~pending_q | free_i)) : '0;
   assign overflow_o = active_i & (|(valid_i & pending_q & ~free_i));

   always_comb begin
      slot_d    = slot_q;
      pending_d = clear_i ? '0 : ((pending_q & ~free_i) | cap);
      for (int i = 0; i < NUM_PE; i++) begin
         if (cap[i]) slot_d[i] = data_i[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q    <= '0;
         pending_q <= '0;
      end else begin
         slot_q    <= slot_d;
         pending_q <= pending_d;
      end
   end

   assign slot_o        = slot_q;
   assign pending_o     = pending_q;
   assign pending_nxt_o = pending_d;

endmodule

// File: rtl/ofm_collector.sv
// ofm_collector -- gathers per-PE output bytes into 16-byte groups and
// writes each group to the OFM buffer as four 32-bit words.
//   clk, reset_n          : clock, async active-low reset
//   start                 : begin a layer (IDLE only)
//   cfg_base_addr         : first word address of the layer
//   cfg_num_pixels        : groups per layer (0 means 1)
//   OFM_0..OFM_15, valid  : per-PE bytes and strobes
//   wr_valid/wr_ready     : write handshake, wr_data/wr_addr payload
//   busy, done            : activity flag, end-of-layer pulse
//   err_overflow          : sticky slot-overrun flag
//
// state      | meaning
// IDLE       | waiting for start, strobes ignored
// COLLECT    | filling slots until all 16 are pending
// DRAIN      | writing words 0..3 of the current group
module ofm_collector
   import ofm_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [15:0]       cfg_num_pixels,
   input  logic [7:0]        OFM_0,
   input  logic [7:0]        OFM_1,
   input  logic [7:0]        OFM_2,
   input  logic [7:0]        OFM_3,
   input  logic [7:0]        OFM_4,
   input  logic [7:0]        OFM_5,
   input  logic [7:0]        OFM_6,
   input  logic [7:0]        OFM_7,
   input  logic [7:0]        OFM_8,
   input  logic [7:0]        OFM_9,
   input  logic [7:0]        OFM_10,
   input  logic [7:0]        OFM_11,
   input  logic [7:0]        OFM_12,
   input  logic [7:0]        OFM_13,
   input  logic [7:0]        OFM_14,
   input  logic [7:0]        OFM_15,
   input  logic [15:0]       valid,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [31:0]       wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done,
   output logic              err_overflow
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          word_q, word_d;
   logic [15:0]         pix_cnt_q, pix_cnt_d;
   logic [15:0]         num_pix_q, num_pix_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [NUM_PE-1:0][7:0] ofm_bus;
   logic [NUM_PE-1:0][7:0] slot;
   logic [NUM_PE-1:0]      pending, pending_nxt, free;
   logic                   overflow;
   logic                   start_acc, accept, last_word, layer_end, clear;
   logic [15:0]            pix_inc;

   assign ofm_bus = {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
                     OFM_7,  OFM_6,  OFM_5,  OFM_4,  OFM_3,  OFM_2,  OFM_1, OFM_0};

   assign start_acc = (state_q == ST_IDLE) && start;
   assign accept    = (state_q == ST_DRAIN) && wr_ready;
   assign last_word = (word_q == 2'(WORDS_PER_PIXEL - 1));
   assign pix_inc   = pix_cnt_q + 16'd1;
   assign layer_end = accept && last_word && (pix_inc == num_pix_q);
   assign free      = accept ? word_mask(word_q) : '0;
   // Leftover bytes of a next group are discarded when the layer ends.
   assign clear     = start_acc || layer_end;

   ofm_slot_bank u_slot_bank (
      .clk          (clk),
      .reset_n      (reset_n),
      .active_i     (state_q != ST_IDLE),
      .clear_i      (clear),
      .valid_i      (valid),
      .free_i       (free),
      .data_i       (ofm_bus),
      .slot_o       (slot),
      .pending_o    (pending),
      .pending_nxt_o(pending_nxt),
      .overflow_o   (overflow)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      word_d    = word_q;
      pix_cnt_d = pix_cnt_q;
      num_pix_d = num_pix_q;
      done_d    = 1'b0;
      err_d     = err_q | overflow;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_COLLECT;
               addr_d    = cfg_base_addr;
               word_d    = 2'd0;
               pix_cnt_d = 16'd0;
               num_pix_d = (cfg_num_pixels == 16'd0) ? 16'd1 : cfg_num_pixels;
               err_d     = 1'b0;
            end
         end
         // Move on the edge that completes the group so the first word is
         // requested in the very next cycle.
         ST_COLLECT: begin
            if (pending_nxt == '1) begin
               state_d = ST_DRAIN;
               word_d  = 2'd0;
            end
         end
         ST_DRAIN: begin
            if (accept) begin
               addr_d = addr_q + ADDR_W'(1);
               word_d = word_q + 2'd1;
               if (last_word) begin
                  pix_cnt_d = pix_inc;
                  if (layer_end) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = (pending_nxt == '1) ? ST_DRAIN : ST_COLLECT;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         word_q    <= '0;
         pix_cnt_q <= '0;
         num_pix_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         word_q    <= word_d;
         pix_cnt_q <= pix_cnt_d;
         num_pix_q <= num_pix_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Slots of the word on offer stay pending until accepted, so the data
   // cannot change under a stalled request.
   assign wr_valid     = (state_q == ST_DRAIN);
   assign wr_data      = slot[{word_q, 2'b00} +: BYTES_PER_WORD];
   assign wr_addr      = addr_q;
   assign busy         = (state_q != ST_IDLE) || (|pending);
   assign done         = done_q;
   assign err_overflow = err_q;

endmodule

// File: doc/ofm_collector.md
OFM_COLLECTOR -- requirements
Module: ofm_collector

Interface
REQ-001 Parameter: ADDR_W, default 16, width of cfg_base_addr and wr_addr.
REQ-002 Clocking and reset SHALL be one clock with asynchronous, active-low reset: clk in 1, the single clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle pulse beginning a layer; honoured only in IDLE.
REQ-005 cfg_base_addr  in  ADDR_W  first word address; sampled on accepted start.
REQ-006 cfg_num_pixels  in  16  number of 16-byte groups per layer; sampled on accepted start; 0 treated as 1.
REQ-007 OFM_0 .. OFM_15  in  8 each  per-PE output bytes from the PE cluster.
REQ-008 valid  in  16  per-PE one-cycle strobe; bit i qualifies OFM_i.
REQ-009 wr_valid  out  1  write request to OFM buffer.
REQ-010 wr_ready  in  1  OFM buffer accepts word when wr_valid && wr_ready.
REQ-011 wr_data  out  32  packed word.
REQ-012 wr_addr  out  ADDR_W  word address.
REQ-013 busy  out  1  high whenever any slot is pending or state is not IDLE; used by the controller to hold PE_finish.
REQ-014 done  out  1  one-cycle pulse after the last word of the layer is accepted.
REQ-015 err_overflow  out  1  sticky error, cleared only by reset or accepted start.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, DRAIN.
REQ-017 IDLE -> COLLECT on start; load addr counter from cfg_base_addr and clear the pixel counter and all pending bits.
REQ-018 In COLLECT and DRAIN, valid[i] with slot i not pending SHALL capture OFM_i into slot i and set pending[i].
REQ-019 valid[i] with slot i pending SHALL drop the data, keep the old slot contents, and set err_overflow.
REQ-020 valid in IDLE SHALL be ignored, with no capture and no error.
REQ-021 COLLECT -> DRAIN in the cycle after pending becomes 16'hFFFF; wr_valid SHALL assert in that first DRAIN cycle (capture-to-request latency 1 cycle).
REQ-022 DRAIN SHALL emit words k = 0,1,2,3 in order, with wr_data = {slot[4k+3], slot[4k+2], slot[4k+1], slot[4k]}.
REQ-023 wr_data and wr_addr SHALL stay stable while wr_valid && !wr_ready; wr_valid SHALL not drop until accepted.
REQ-024 On acceptance of word k, pending[4k+3:4k] SHALL clear and wr_addr SHALL increment by 1, wrapping modulo 2^ADDR_W.
REQ-025 If slot i is freed and valid[i] is high in the same cycle, the new data SHALL be captured, pending[i] SHALL stay set, and no error is raised.
REQ-026 After word 3 is accepted, the pixel counter SHALL increment; if it equals cfg_num_pixels, pulse done and go to IDLE, else go to COLLECT.
REQ-027 Pending bits set during DRAIN for an already-drained group SHALL count toward the next pixel; they are discarded on the transition to IDLE.
REQ-028 start outside IDLE SHALL be ignored.

Reset
REQ-029 On reset_n low, regardless of clk: state = IDLE, pending = 0, slots = 0, wr_valid = 0, wr_data = 0, wr_addr = 0, done = 0, err_overflow = 0, busy = 0, counters = 0.
REQ-030 Reset mid-DRAIN SHALL abandon the current group; no word is emitted after reset release until a new start.

Structure
REQ-031 Package ofm_pkg SHALL hold NUM_PE = 16, BYTES_PER_WORD = 4, WORDS_PER_PIXEL = 4, and the state enum type.
REQ-032 One sub-module, ofm_slot_bank, SHALL hold the 16 byte slots and pending bits with capture, free and overflow logic; FSM, counters and handshake stay in ofm_collector.

Verification
REQ-033 Basic pixel: start with base = 0x0100 and num_pixels = 1; pulse all valid together with OFM_i = i; wr_ready = 1 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C at addresses 0x0100..0x0103, then done pulses and busy falls.
REQ-034 Staggered arrival: valid bits one per cycle over 16 cycles -> wr_valid first high the cycle after valid[15]; data identical to REQ-033.
REQ-035 Backpressure: wr_ready low for 5 cycles on word 1 -> wr_data holds 0x07060504 and wr_addr holds 0x0101 throughout; no word is lost or duplicated.
REQ-036 Overflow: valid[2] twice before drain (0x11, then 0x22) -> err_overflow = 1 and word 0 byte 2 = 0x11.
REQ-037 Overlap and wrap: base = 0xFFFE, num_pixels = 2; second pixel's valid[3:0] arrives in the cycle word 0 is accepted -> no error, addresses 0xFFFE, 0xFFFF, 0x0000..0x0005, a single done pulse.
REQ-038 Reset mid-DRAIN after word 1 is accepted -> all outputs zero; a subsequent start with num_pixels = 1 completes normally.
